// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: default sizes,
// FSM encoding, the double-dabble correction threshold and a sizing check.
package bcd_pkg;

   localparam int W_DEF      = 16;
   localparam int DIGITS_DEF = 5;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // True when 10^d >= 2^w, i.e. d decimal digits can hold any w-bit value.
   function automatic bit digits_ok(input int w, input int d);
      real p2;
      real p10;
      p2  = 1.0;
      p10 = 1.0;
      for (int i = 0; i < w; i++) p2 = p2 * 2.0;
      for (int i = 0; i < d; i++) p10 = p10 * 10.0;
      return (p10 >= p2);
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BCD_CONVERTER_BLANK_EN to build the registered leading-zero blank mask.
module bcd_converter
   import bcd_pkg::*;
#(
   parameter int w      = W_DEF,
   parameter int digits = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [w-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*digits-1:0]   bcd,
   output logic [digits-1:0]     blank
);

   localparam int CNT_W = $clog2(w + 1);
   localparam int BCD_W = 4 * digits;

   if (!digits_ok(w, digits)) begin : g_size_check
      $error("bcd_converter: digits=%0d cannot represent %0d-bit values", digits, w);
   end

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [BCD_W-1:0]  scratch;
   logic [BCD_W-1:0]  scratch_adj;
   logic [w-1:0]      bin_sr;
   logic              accept;
   logic              step;
   logic              last_step;

   // busy drops one cycle before done, so a start seen in the final cycle
   // overlaps the result write-back and sustains one result per w+1 cycles.
   assign accept    = start && !busy;
   assign step      = (state == CONVERT) && (cnt != '0);
   assign last_step = (state == CONVERT) && (cnt == '0);

   for (genvar i = 0; i < digits; i++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (scratch[4*i +: 4]),
         .dout (scratch_adj[4*i +: 4])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = CONVERT;
         end
         CONVERT: begin
            if (last_step && !accept) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         scratch <= '0;
         bin_sr  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
      end else begin
         done <= last_step;
         if (last_step) begin
            bcd <= scratch;
         end
         if (accept) begin
            bin_sr  <= bin;
            scratch <= '0;
            cnt     <= CNT_W'(w);
            busy    <= 1'b1;
         end else if (step) begin
            {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
            cnt               <= cnt - CNT_W'(1);
            busy              <= (cnt != CNT_W'(1));
         end
      end
   end

`ifdef BCD_CONVERTER_BLANK_EN
   logic [digits-1:0] zero_above;

   // zero_above[i] is set when digit i and every higher digit are zero.
   always_comb begin
      zero_above = '0;
      zero_above[digits-1] = (scratch[BCD_W-1 -: 4] == 4'd0);
      for (int i = digits - 2; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] && (scratch[4*i +: 4] == 4'd0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blank <= '0;
      end else if (last_step) begin
         blank <= zero_above & ~digits'(1);
      end
   end
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Directed and randomized bench for bcd_converter against a decimal reference model.
`timescale 1ns/1ps
module tb_bcd_converter;

   localparam int W   = 16;
   localparam int D   = 5;
   localparam int LAT = W + 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [W-1:0]   bin;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd;
   logic [D-1:0]   blank;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_converter #(.w(W), .digits(D)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .blank (blank)
   );

   function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
      int unsigned x;
      x = v;
      ref_bcd = '0;
      for (int i = 0; i < D; i++) begin
         ref_bcd[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
   endfunction

   function automatic logic [D-1:0] ref_blank(input int unsigned v);
      ref_blank = '0;
`ifdef BCD_CONVERTER_BLANK_EN
      begin
         int unsigned p;
         p = 10;
         for (int i = 1; i < D; i++) begin
            ref_blank[i] = (v < p);
            p = p * 10;
         end
      end
`else
      if (v > 32'hFFFF_FFFF) ref_blank = '1;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated conversion; with poke set, start is pulsed twice mid-run.
   task automatic run_one(input int unsigned v, input bit poke, input string tag);
      int n;
      int busy_cycles;
      int extra_dones;
      bin   = W'(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      bin   = W'($urandom);
      n = 0;
      busy_cycles = 0;
      while (!done && n < 4 * LAT) begin
         if (busy) busy_cycles++;
         if (poke) begin
            start = (n == 3 || n == 9);
            bin   = W'($urandom);
         end
         tick();
         n++;
      end
      start = 1'b0;
      check({tag, " latency"}, 32'(n), 32'(LAT));
      check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(W));
      check({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(v)));
      check({tag, " blank"}, 32'(blank), 32'(ref_blank(v)));
      check({tag, " busy_at_done"}, 32'(busy), 32'(0));
      tick();
      check({tag, " done_width"}, 32'(done), 32'(0));
      extra_dones = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         if (done) extra_dones++;
         tick();
      end
      check({tag, " extra_dones"}, 32'(extra_dones), 32'(0));
      check({tag, " bcd_hold"}, 32'(bcd), 32'(ref_bcd(v)));
   endtask

   // start held high; the model accepts every LAT edges and checks each result.
   task automatic stream(input int n_conv, input bit rnd, input string tag);
      logic [W-1:0] q[$];
      logic [W-1:0] e;
      int last;
      last  = n_conv * LAT;
      bin   = rnd ? W'($urandom) : W'(0);
      start = 1'b1;
      for (int c = 0; c <= last + LAT; c++) begin
         @(posedge clk);
         if (c % LAT == 0 && c <= last) q.push_back(bin);
         #1;
         if (c >= LAT && c % LAT == 0) begin
            check({tag, " done"}, 32'(done), 32'(1));
            if (q.size() != 0) begin
               e = q.pop_front();
               check({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(32'(e))));
               check({tag, " blank"}, 32'(blank), 32'(ref_blank(32'(e))));
            end
         end else begin
            check({tag, " no_done"}, 32'(done), 32'(0));
         end
         start = (c + 1 <= last);
         bin   = rnd ? W'($urandom) : W'((c + 1) % 100);
      end
      start = 1'b0;
      check({tag, " queue_empty"}, 32'(q.size()), 32'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dones;
      reset = 1'b0;
      start = 1'b0;
      bin   = '0;
      repeat (3) tick();
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset bcd", 32'(bcd), 32'(0));
      check("reset blank", 32'(blank), 32'(0));
      reset = 1'b1;

      run_one(12345, 1'b0, "v12345");
      run_one(32'hFFFF, 1'b0, "vFFFF");
      run_one(0, 1'b0, "v0");
      run_one(42, 1'b1, "v42_poke");

      // Reset in the middle of converting 999.
      bin   = W'(999);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      reset = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'(0));
      check("abort done", 32'(done), 32'(0));
      check("abort bcd", 32'(bcd), 32'(0));
      check("abort blank", 32'(blank), 32'(0));
      tick();
      tick();
      reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         if (done) dones++;
         tick();
      end
      check("abort no_done", 32'(dones), 32'(0));
      check("abort bcd_after", 32'(bcd), 32'(0));
      check("abort busy_after", 32'(busy), 32'(0));
      run_one(7, 1'b0, "v7");

      stream(100, 1'b0, "step");
      repeat (3) tick();
      stream(2000, 1'b1, "rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
